empaquetador_pixeles_mem: RTL and testbench

Write-side counterpart of the pixel input buffer. The block accepts processed pixels from the filter datapath one per cycle and packs them MSB-first into 32-bit memory words. It buffers up to `FIFO_WORDS` complete words for the memory writer and supports a flush that pads a partial word at the end of an image.

---
 rtl/empaquetador_pixeles_mem_pkg.sv | 20 ++
 rtl/empaquetador_pixeles_mem_fifo.sv | 72 +++++++
 rtl/empaquetador_pixeles_mem.sv | 166 ++++++++++++++++
 tb/tb_empaquetador_pixeles_mem.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/empaquetador_pixeles_mem_pkg.sv
// ---------------------------------------------------------------------------
// pkg_filtros
// Shared constants and types for the filter write-side blocks.
//   MEM_WORD_BITS      : width of one memory word
//   PIXEL_BITS         : width of one processed pixel
//   BYTES_POR_PALABRA  : pixels packed into one memory word
//   estado_t           : flush state machine encoding (E_ACTIVO/E_PENDIENTE)
// ---------------------------------------------------------------------------
package pkg_filtros;

   localparam int MEM_WORD_BITS     = 32;
   localparam int PIXEL_BITS        = 8;
   localparam int BYTES_POR_PALABRA = 4;

   typedef enum logic {
      E_ACTIVO    = 1'b0,
      E_PENDIENTE = 1'b1
   } estado_t;

endpackage : pkg_filtros

// File: rtl/empaquetador_pixeles_mem_fifo.sv
// ---------------------------------------------------------------------------
// fifo_palabras_mem
// Small FIFO of packed memory words with combinational head read.
// Push and pop may happen in the same cycle, including when full: the pop
// frees the slot the push is about to use.
// Ports:
//   clk_i       : clock, rising edge
//   reset_ni    : asynchronous active-low reset (clears storage too)
//   push_i      : write push_data_i at the tail (dropped if full and no pop)
//   push_data_i : word to store
//   pop_i       : discard the head word (ignored when empty)
//   data_o      : head word, mem[rd_ptr]
//   full_o      : FIFO holds FIFO_WORDS words
//   empty_o     : FIFO holds no words
// ---------------------------------------------------------------------------
module fifo_palabras_mem #(
   parameter int WORD_BITS  = 32,
   parameter int FIFO_WORDS = 4
) (
   input  logic                 clk_i,
   input  logic                 reset_ni,
   input  logic                 push_i,
   input  logic [WORD_BITS-1:0] push_data_i,
   input  logic                 pop_i,
   output logic [WORD_BITS-1:0] data_o,
   output logic                 full_o,
   output logic                 empty_o
);

   localparam int PTR_W = $clog2(FIFO_WORDS);
   localparam int CNT_W = PTR_W + 1;

   logic [WORD_BITS-1:0] mem_q [FIFO_WORDS];
   logic [PTR_W-1:0]     wr_ptr_q;
   logic [PTR_W-1:0]     rd_ptr_q;
   logic [CNT_W-1:0]     count_q;
   logic                 do_push;
   logic                 do_pop;

   assign full_o  = (count_q == CNT_W'(FIFO_WORDS));
   assign empty_o = (count_q == '0);
   assign data_o  = mem_q[rd_ptr_q];

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   // Pointers are exactly log2(depth) bits, so they wrap naturally.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         for (int i = 0; i < FIFO_WORDS; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule : fifo_palabras_mem

// File: rtl/empaquetador_pixeles_mem.sv
// ---------------------------------------------------------------------------
// empaquetador_pixeles_mem
// Packs filtered pixels MSB-first into memory words and queues the complete
// words for the memory writer. A flush closes a partial word by zero-padding
// its unfilled low bytes.
// Ports:
//   clk             : clock, rising edge
//   reset           : asynchronous active-low reset
//   pixel           : pixel from the filter datapath
//   write_pixel     : pixel valid; taken only while space_available=1
//   flush           : one-cycle request to close the current partial word
//   word_taken      : memory writer consumed memory_data
//   memory_data     : head-of-FIFO word
//   data_available  : FIFO holds at least one word
//   space_available : a pixel presented this cycle will be accepted
//   flush_done      : one-cycle pulse when a flush completes
// ---------------------------------------------------------------------------
module empaquetador_pixeles_mem #(
   parameter int MEM_WORD_BITS = pkg_filtros::MEM_WORD_BITS,
   parameter int PIXEL_BITS    = pkg_filtros::PIXEL_BITS,
   parameter int FIFO_WORDS    = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [PIXEL_BITS-1:0]    pixel,
   input  logic                     write_pixel,
   input  logic                     flush,
   input  logic                     word_taken,
   output logic [MEM_WORD_BITS-1:0] memory_data,
   output logic                     data_available,
   output logic                     space_available,
   output logic                     flush_done
);

   import pkg_filtros::*;

   localparam logic [1:0] ULTIMO_BYTE = 2'(BYTES_POR_PALABRA - 1);

   estado_t                  estado_q, estado_d;
   logic [1:0]               cnt_q, cnt_d;
   logic [PIXEL_BITS-1:0]    b0_q, b0_d;
   logic [PIXEL_BITS-1:0]    b1_q, b1_d;
   logic [PIXEL_BITS-1:0]    b2_q, b2_d;
   logic                     flush_done_q, flush_done_d;

   logic                     pending;
   logic                     accept;
   logic                     pop;
   logic                     push;
   logic [MEM_WORD_BITS-1:0] push_word;
   logic                     fifo_full;
   logic                     fifo_empty;

   // Zero-pads a partial word: only the first n held bytes are kept, so stale
   // bytes left over from an earlier word never leak into the padding.
   function automatic logic [MEM_WORD_BITS-1:0] rellenar(
      input logic [PIXEL_BITS-1:0] p0,
      input logic [PIXEL_BITS-1:0] p1,
      input logic [PIXEL_BITS-1:0] p2,
      input logic [1:0]            n
   );
      logic [MEM_WORD_BITS-1:0] w;
      case (n)
         2'd1:    w = {p0, {(3*PIXEL_BITS){1'b0}}};
         2'd2:    w = {p0, p1, {(2*PIXEL_BITS){1'b0}}};
         2'd3:    w = {p0, p1, p2, {PIXEL_BITS{1'b0}}};
         default: w = '0;
      endcase
      return w;
   endfunction

   // Handshake flags come from registered state only; a same-cycle pop does
   // not open space for the pixel that would complete a word.
   assign pending         = (estado_q == E_PENDIENTE);
   assign space_available = ~pending & ~(fifo_full & (cnt_q == ULTIMO_BYTE));
   assign accept          = write_pixel & space_available;
   assign pop             = word_taken & ~fifo_empty;
   assign data_available  = ~fifo_empty;
   assign flush_done      = flush_done_q;

   always_comb begin
      estado_d     = estado_q;
      cnt_d        = cnt_q;
      b0_d         = b0_q;
      b1_d         = b1_q;
      b2_d         = b2_q;
      flush_done_d = 1'b0;
      push         = 1'b0;
      push_word    = '0;

      unique case (estado_q)
         E_ACTIVO: begin
            if (accept) begin
               case (cnt_q)
                  2'd0:    b0_d = pixel;
                  2'd1:    b1_d = pixel;
                  2'd2:    b2_d = pixel;
                  default: begin
                     push      = 1'b1;
                     push_word = {b0_q, b1_q, b2_q, pixel};
                  end
               endcase
               cnt_d = cnt_q + 2'd1;
            end
            // A pixel accepted together with flush belongs to the word being
            // closed, so it is folded in before deciding whether padding is
            // needed.
            if (flush) begin
               if (accept && (cnt_q == ULTIMO_BYTE)) begin
                  flush_done_d = 1'b1;
               end else if (!accept && (cnt_q == 2'd0)) begin
                  flush_done_d = 1'b1;
               end else begin
                  estado_d = E_PENDIENTE;
               end
            end
         end

         E_PENDIENTE: begin
            // Wait for a free slot (or one freed by this cycle's pop).
            if (!fifo_full || pop) begin
               push         = 1'b1;
               push_word    = rellenar(b0_q, b1_q, b2_q, cnt_q);
               cnt_d        = 2'd0;
               flush_done_d = 1'b1;
               estado_d     = E_ACTIVO;
            end
         end

         default: estado_d = E_ACTIVO;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado_q     <= E_ACTIVO;
         cnt_q        <= 2'd0;
         b0_q         <= '0;
         b1_q         <= '0;
         b2_q         <= '0;
         flush_done_q <= 1'b0;
      end else begin
         estado_q     <= estado_d;
         cnt_q        <= cnt_d;
         b0_q         <= b0_d;
         b1_q         <= b1_d;
         b2_q         <= b2_d;
         flush_done_q <= flush_done_d;
      end
   end

   fifo_palabras_mem #(
      .WORD_BITS  (MEM_WORD_BITS),
      .FIFO_WORDS (FIFO_WORDS)
   ) u_fifo (
      .clk_i       (clk),
      .reset_ni    (reset),
      .push_i      (push),
      .push_data_i (push_word),
      .pop_i       (pop),
      .data_o      (memory_data),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

endmodule : empaquetador_pixeles_mem

// File: tb/tb_empaquetador_pixeles_mem.sv
// ---------------------------------------------------------------------------
// tb_empaquetador_pixeles_mem
// Directed vectors for the pixel packer: each record gives the inputs held
// for one clock and the outputs expected just after that edge.
// ---------------------------------------------------------------------------
module tb_empaquetador_pixeles_mem;

   logic        clk;
   logic        reset;
   logic [7:0]  pixel;
   logic        write_pixel;
   logic        flush;
   logic        word_taken;
   logic [31:0] memory_data;
   logic        data_available;
   logic        space_available;
   logic        flush_done;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic        wp;
      logic [7:0]  px;
      logic        fl;
      logic        wt;
      logic [31:0] md;
      logic        chk_md;
      logic        da;
      logic        sa;
      logic        fd;
   } vec_t;

   vec_t vq[$];

   empaquetador_pixeles_mem #(
      .MEM_WORD_BITS (32),
      .PIXEL_BITS    (8),
      .FIFO_WORDS    (4)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .pixel           (pixel),
      .write_pixel     (write_pixel),
      .flush           (flush),
      .word_taken      (word_taken),
      .memory_data     (memory_data),
      .data_available  (data_available),
      .space_available (space_available),
      .flush_done      (flush_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end else begin
         passed++;
      end
   endtask

   function automatic void add(input logic wp, input logic [7:0] px, input logic fl,
                               input logic wt, input logic [31:0] md, input logic cm,
                               input logic da, input logic sa, input logic fd);
      vec_t v;
      v.wp = wp; v.px = px; v.fl = fl; v.wt = wt;
      v.md = md; v.chk_md = cm; v.da = da; v.sa = sa; v.fd = fd;
      vq.push_back(v);
   endfunction

   // Inputs change on the falling edge; outputs are sampled 1 time unit after
   // the rising edge that consumed them.
   task automatic step(input logic wp, input logic [7:0] px, input logic fl, input logic wt);
      @(negedge clk);
      write_pixel = wp;
      pixel       = px;
      flush       = fl;
      word_taken  = wt;
      @(posedge clk);
      #1;
   endtask

   // Four full words base..base+15 pushed into an empty FIFO with no pops.
   function automatic void fill_four(input logic [7:0] base);
      logic [31:0] head;
      head = {base, base + 8'd1, base + 8'd2, base + 8'd3};
      for (int i = 0; i < 16; i++) begin
         add(1'b1, base + 8'(i), 1'b0, 1'b0, head, (i >= 3), (i >= 3), 1'b1, 1'b0);
      end
   endfunction

   initial begin
      reset       = 1'b0;
      pixel       = 8'h00;
      write_pixel = 1'b0;
      flush       = 1'b0;
      word_taken  = 1'b0;

      // ---- basic word assembly and pop ----
      add(1, 8'h11, 0, 0, 32'h0, 1, 0, 1, 0);
      add(1, 8'h22, 0, 0, 32'h0, 1, 0, 1, 0);
      add(1, 8'h33, 0, 0, 32'h0, 1, 0, 1, 0);
      add(1, 8'h44, 0, 0, 32'h11223344, 1, 1, 1, 0);
      add(0, 8'h00, 0, 1, 32'h0, 0, 0, 1, 0);

      // ---- fill to full, back-pressure on the 4th byte, drop, resume ----
      fill_four(8'h00);
      add(1, 8'h10, 0, 0, 32'h00010203, 1, 1, 1, 0);
      add(1, 8'h11, 0, 0, 32'h00010203, 1, 1, 1, 0);
      add(1, 8'h12, 0, 0, 32'h00010203, 1, 1, 0, 0);
      add(1, 8'h13, 0, 0, 32'h00010203, 1, 1, 0, 0);   // dropped
      add(0, 8'h00, 0, 1, 32'h04050607, 1, 1, 1, 0);   // pop reopens space
      add(1, 8'h13, 0, 0, 32'h04050607, 1, 1, 1, 0);   // completes 10111213
      add(0, 8'h00, 0, 1, 32'h08090A0B, 1, 1, 1, 0);
      add(0, 8'h00, 0, 1, 32'h0C0D0E0F, 1, 1, 1, 0);
      add(0, 8'h00, 0, 1, 32'h10111213, 1, 1, 1, 0);
      add(0, 8'h00, 0, 1, 32'h0, 0, 0, 1, 0);

      // ---- flush of a 2-byte partial word with a free slot ----
      add(1, 8'hAA, 0, 0, 32'h0, 0, 0, 1, 0);
      add(1, 8'hBB, 0, 0, 32'h0, 0, 0, 1, 0);
      add(0, 8'h00, 1, 0, 32'h0, 0, 0, 0, 0);          // PENDIENTE
      add(0, 8'h00, 0, 0, 32'hAABB0000, 1, 1, 1, 1);
      add(0, 8'h00, 0, 0, 32'hAABB0000, 1, 1, 1, 0);
      add(0, 8'h00, 0, 1, 32'h0, 0, 0, 1, 0);
      // flush on an empty assembly stage: pulse only, nothing pushed
      add(0, 8'h00, 1, 0, 32'h0, 0, 0, 1, 1);
      add(0, 8'h00, 0, 0, 32'h0, 0, 0, 1, 0);
      // flush together with the completing 4th pixel
      add(1, 8'hD0, 0, 0, 32'h0, 0, 0, 1, 0);
      add(1, 8'hD1, 0, 0, 32'h0, 0, 0, 1, 0);
      add(1, 8'hD2, 0, 0, 32'h0, 0, 0, 1, 0);
      add(1, 8'hD3, 1, 0, 32'hD0D1D2D3, 1, 1, 1, 1);
      add(0, 8'h00, 0, 1, 32'h0, 0, 0, 1, 0);

      // ---- flush while full: wait in PENDIENTE until a pop ----
      fill_four(8'h20);
      add(1, 8'hC1, 0, 0, 32'h20212223, 1, 1, 1, 0);
      add(1, 8'hC2, 0, 0, 32'h20212223, 1, 1, 1, 0);
      add(0, 8'h00, 1, 0, 32'h20212223, 1, 1, 0, 0);
      add(1, 8'hC3, 1, 0, 32'h20212223, 1, 1, 0, 0);   // pixel and flush ignored
      add(0, 8'h00, 0, 1, 32'h24252627, 1, 1, 1, 1);   // pop + padded push
      add(0, 8'h00, 0, 1, 32'h28292A2B, 1, 1, 1, 0);
      add(0, 8'h00, 0, 1, 32'h2C2D2E2F, 1, 1, 1, 0);
      add(0, 8'h00, 0, 1, 32'hC1C20000, 1, 1, 1, 0);
      add(0, 8'h00, 0, 1, 32'h0, 0, 0, 1, 0);

      // ---- full FIFO with continuous pops while the 4th pixel arrives ----
      fill_four(8'h40);
      add(1, 8'h50, 0, 0, 32'h40414243, 1, 1, 1, 0);
      add(1, 8'h51, 0, 0, 32'h40414243, 1, 1, 1, 0);
      add(1, 8'h52, 0, 0, 32'h40414243, 1, 1, 0, 0);
      add(1, 8'h53, 0, 1, 32'h44454647, 1, 1, 1, 0);   // dropped, pop done
      add(1, 8'h53, 0, 1, 32'h48494A4B, 1, 1, 1, 0);   // push + pop together
      add(0, 8'h00, 0, 1, 32'h4C4D4E4F, 1, 1, 1, 0);
      add(0, 8'h00, 0, 1, 32'h50515253, 1, 1, 1, 0);
      add(0, 8'h00, 0, 1, 32'h0, 0, 0, 1, 0);

      // ---- reset state ----
      repeat (2) @(negedge clk);
      #1;
      chk("rst md", memory_data, 32'h0);
      chk("rst da", {31'b0, data_available}, 32'd0);
      chk("rst sa", {31'b0, space_available}, 32'd1);
      chk("rst fd", {31'b0, flush_done}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // ---- table ----
      for (int i = 0; i < vq.size(); i++) begin
         step(vq[i].wp, vq[i].px, vq[i].fl, vq[i].wt);
         if (vq[i].chk_md) chk($sformatf("v%0d md", i), memory_data, vq[i].md);
         chk($sformatf("v%0d da", i), {31'b0, data_available},  {31'b0, vq[i].da});
         chk($sformatf("v%0d sa", i), {31'b0, space_available}, {31'b0, vq[i].sa});
         chk($sformatf("v%0d fd", i), {31'b0, flush_done},      {31'b0, vq[i].fd});
      end

      // ---- reset in the middle of a word, with a word queued ----
      for (int i = 0; i < 4; i++) step(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
      step(1'b1, 8'h60, 1'b0, 1'b0);
      step(1'b1, 8'h61, 1'b0, 1'b0);
      chk("pre-rst md", memory_data, 32'h70717273);
      @(negedge clk);
      write_pixel = 1'b0;
      reset       = 1'b0;
      #1;
      chk("mid rst md", memory_data, 32'h0);
      chk("mid rst da", {31'b0, data_available}, 32'd0);
      chk("mid rst sa", {31'b0, space_available}, 32'd1);
      chk("mid rst fd", {31'b0, flush_done}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) step(1'b1, 8'h90 + 8'(i), 1'b0, 1'b0);
      chk("post-rst md", memory_data, 32'h90919293);
      chk("post-rst da", {31'b0, data_available}, 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("post-rst drain da", {31'b0, data_available}, 32'd0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("post-rst flush fd", {31'b0, flush_done}, 32'd1);
      chk("post-rst flush da", {31'b0, data_available}, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_empaquetador_pixeles_mem
